sequential_multiplier: RTL and testbench

Iterative radix-2 shift-add multiplier with a start/done handshake and a runtime signed/unsigned mode. It is parametrised in operand width and produces a full double-width product in WIDTH+1 cycles. It is the multi-cycle multiply unit behind the datapath, sharing the clock and reset of the register file and PC flops.

---
 rtl/sequential_multiplier_pkg.sv | 18 +
 rtl/sequential_multiplier_if.sv | 22 ++
 rtl/adder.sv | 10 +
 rtl/magnitude_negate.sv | 12 +
 rtl/sequential_multiplier.sv | 123 ++++++++++++
 tb/tb_sequential_multiplier.sv | 194 +++++++++++++++++++
 6 files changed

// File: rtl/sequential_multiplier_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_FINISH
  } mul_state_t;

  localparam int unsigned MinWidth = 2;
  localparam int unsigned MaxWidth = 64;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sequential_multiplier_if.sv
// Start/done handshake, operands and result of the multiply unit.
interface sequential_multiplier_if #(
  parameter int unsigned WIDTH = 32
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/adder.sv
// Plain unsigned adder; callers size it one bit wider when they need the carry.
module adder #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

// File: rtl/magnitude_negate.sv
// Conditional two's-complement negate, used for operand magnitude and result sign.
module magnitude_negate #(
  parameter int unsigned Width = 8
) (
  input  logic             neg_i,
  input  logic [Width-1:0] val_i,
  output logic [Width-1:0] val_o
);
  always_comb begin
    val_o = neg_i ? -val_i : val_i;
  end
endmodule

// File: rtl/sequential_multiplier.sv
// Radix-2 shift-add multiplier: sign-magnitude operands, WIDTH+1 cycle latency.
module sequential_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  sequential_multiplier_if.slave bus
);
  localparam int unsigned CntW  = cnt_width(WIDTH);
  localparam int unsigned ProdW = 2 * WIDTH;

  mul_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ProdW:0]    acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ProdW-1:0]  product_q, product_d;

  logic [WIDTH-1:0]  a_abs, b_abs, addend;
  logic [WIDTH:0]    psum;
  logic [ProdW-1:0]  acc_signed;

  magnitude_negate #(.Width(WIDTH)) u_abs_a (
    .neg_i (bus.signed_mode & bus.a[WIDTH-1]),
    .val_i (bus.a),
    .val_o (a_abs)
  );

  magnitude_negate #(.Width(WIDTH)) u_abs_b (
    .neg_i (bus.signed_mode & bus.b[WIDTH-1]),
    .val_i (bus.b),
    .val_o (b_abs)
  );

  magnitude_negate #(.Width(ProdW)) u_neg_prod (
    .neg_i (neg_q),
    .val_i (acc_q[ProdW-1:0]),
    .val_o (acc_signed)
  );

  assign addend = mplier_q[0] ? mcand_q : '0;

  // Upper half is WIDTH+1 bits so the partial-sum carry is never lost.
  adder #(.Width(WIDTH + 1)) u_adder (
    .a_i   (acc_q[ProdW:WIDTH]),
    .b_i   ({1'b0, addend}),
    .sum_o (psum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (bus.start) begin
          mcand_d  = a_abs;
          mplier_d = b_abs;
          neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CntW'(WIDTH);
          busy_d   = 1'b1;
          state_d  = MUL_RUN;
        end
      end
      MUL_RUN: begin
        acc_d    = {1'b0, psum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = MUL_FINISH;
        end
      end
      MUL_FINISH: begin
        product_d = acc_signed;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= MUL_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench: 8-bit directed vectors and corner sequences, 32-bit randomized stream.
module tb_sequential_multiplier;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   done32_cnt = 0;
  int   accepted32 = 0;

  always #5 clock = ~clock;

  sequential_multiplier_if #(.WIDTH(8))  if8 ();
  sequential_multiplier_if #(.WIDTH(32)) if32 ();

  sequential_multiplier #(.WIDTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (if8)
  );

  sequential_multiplier #(.WIDTH(32)) dut32 (
    .clock (clock),
    .reset (reset),
    .bus   (if32)
  );

  always @(negedge clock) begin
    if (if32.done === 1'b1) done32_cnt++;
  end

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic sm, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One 8-bit operation: checks busy after accept, exact done edge, product, single-cycle done.
  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input bit scramble, input string name);
    int early;
    early = 0;
    if8.signed_mode = sm;
    if8.a           = a;
    if8.b           = b;
    if8.start       = 1'b1;
    @(posedge clock);
    #1;
    if8.start = 1'b0;
    check({name, " busy_after_accept"}, 64'(if8.busy), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      if (scramble) begin
        if8.a           = 8'($urandom);
        if8.b           = 8'($urandom);
        if8.signed_mode = 1'($urandom);
        if8.start       = 1'($urandom);
      end
      @(posedge clock);
      #1;
      if (if8.done !== 1'b0) early++;
    end
    if8.start = 1'b0;
    check({name, " no_early_done"}, 64'(early), 64'd0);
    @(posedge clock);
    #1;
    check({name, " done"}, 64'(if8.done), 64'd1);
    check({name, " busy_at_done"}, 64'(if8.busy), 64'd0);
    check({name, " product"}, 64'(if8.product), 64'(exp));
    @(posedge clock);
    #1;
    check({name, " done_one_cycle"}, 64'(if8.done), 64'd0);
    check({name, " idle_after"}, 64'(if8.busy), 64'd0);
  endtask

  initial begin
    vec_t tbl[8];
    logic [31:0] ra, rb;
    logic        rsm;
    logic [63:0] rexp;

    tbl[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ff_ff"};
    tbl[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, "s_min_min"};
    tbl[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080, "s_min_max"};
    tbl[3] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, "s_m1_1"};
    tbl[4] = '{1'b0, 8'h00, 8'h00, 16'h0000, "u_zero"};
    tbl[5] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, "s_max_max"};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 16'h4000, "u_80_80"};
    tbl[7] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, "s_m1_m1"};

    reset = 1'b1;
    if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.a = '0;  if8.b = '0;
    if32.start = 1'b0; if32.signed_mode = 1'b0; if32.a = '0; if32.b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy8", 64'(if8.busy), 64'd0);
    check("reset done8", 64'(if8.done), 64'd0);
    check("reset product8", 64'(if8.product), 64'd0);
    check("reset busy32", 64'(if32.busy), 64'd0);
    check("reset done32", 64'(if32.done), 64'd0);
    check("reset product32", if32.product, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run8(tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, tbl[i].name);
    end

    // Operands, mode and start toggle every cycle while busy; -100 * 7 = -700.
    run8(1'b1, 8'h9C, 8'h07, 16'hFD44, 1'b1, "stability");

    // Abort in the middle of RUN; outputs must clear at once.
    if8.signed_mode = 1'b0;
    if8.a           = 8'd200;
    if8.b           = 8'd100;
    if8.start       = 1'b1;
    @(posedge clock);
    #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort product", 64'(if8.product), 64'd0);
    check("abort done", 64'(if8.done), 64'd0);
    check("abort busy", 64'(if8.busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run8(1'b0, 8'd13, 8'd11, 16'd143, 1'b0, "after_abort");

    // 32-bit back-to-back stream with start held high and junk operands while busy.
    if32.start = 1'b1;
    for (int j = 0; j < 1200; j++) begin
      ra  = pick32();
      rb  = pick32();
      rsm = 1'($urandom);
      rexp = ref_mul(rsm, ra, rb);
      if32.a           = ra;
      if32.b           = rb;
      if32.signed_mode = rsm;
      @(posedge clock);
      accepted32++;
      for (int i = 0; i < 33; i++) begin
        #1;
        if32.a           = $urandom;
        if32.b           = $urandom;
        if32.signed_mode = 1'($urandom);
        @(posedge clock);
      end
      #1;
      check("rand32 done", 64'(if32.done), 64'd1);
      check("rand32 product", if32.product, rexp);
    end
    if32.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rand32 done_count", 64'(done32_cnt), 64'(accepted32));
    check("rand32 idle", 64'(if32.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
